// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parameterised VGA raster timing generator.
// Counts pixels and lines, and produces hsync/vsync/blank plus
// line/frame start strobes for the downstream sprite and paddle renderers.
// All registered outputs are computed from next-state counter values, so
// sync, blank and the strobes line up with the hcount/vcount of the same cycle.

module vga_sync_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 56,
  parameter int   H_SYNC   = 120,
  parameter int   H_BP     = 64,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 37,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   CLK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        pix_en,
  output logic        line_start,
  output logic        frame_start
);

  // Derived raster totals
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sized decode constants so every compare is width-matched
  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_VIS_END = 12'(H_ACTIVE);
  localparam logic [11:0] HS_FIRST  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_VIS_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_FIRST  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);

  // Elaboration-time sanity checks on the mode parameters
  if (H_TOTAL > 4096) begin : g_err_htotal
    $error("vga_sync_gen: H_TOTAL=%0d does not fit the 12-bit hcount", H_TOTAL);
  end
  if (V_TOTAL > 2048) begin : g_err_vtotal
    $error("vga_sync_gen: V_TOTAL=%0d does not fit the 11-bit vcount", V_TOTAL);
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_err_hparam
    $error("vga_sync_gen: horizontal active/porch/sync parameters must be non-zero");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_vparam
    $error("vga_sync_gen: vertical active/porch/sync parameters must be non-zero");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_err_div
    $error("vga_sync_gen: CLK_DIV=%0d outside 1..16", CLK_DIV);
  end

  logic [3:0]  dcnt;
  logic        h_wrap;
  logic        v_wrap;
  logic [11:0] h_next;
  logic [10:0] v_next;
  logic        hs_active_next;
  logic        vs_active_next;
  logic        blank_next;

  // Pixel enable is a pure decode of the registered divider count
  assign pix_en = (dcnt == DIV_LAST);

  // Clock divider: counts clk cycles within one pixel period and wraps on pix_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= 4'd0;
    end else if (pix_en) begin
      dcnt <= 4'd0;
    end else begin
      dcnt <= dcnt + 4'd1;
    end
  end

  // Next-state raster position, including line and frame wrap detection
  always_comb begin
    h_wrap = pix_en && (hcount == H_LAST);
    v_wrap = h_wrap && (vcount == V_LAST);
    h_next = hcount;
    v_next = vcount;
    if (pix_en) begin
      if (h_wrap) begin
        h_next = 12'd0;
      end else begin
        h_next = hcount + 12'd1;
      end
    end
    if (h_wrap) begin
      if (v_wrap) begin
        v_next = 11'd0;
      end else begin
        v_next = vcount + 11'd1;
      end
    end
  end

  // Sync and blank windows decoded from the next position so they register in step
  always_comb begin
    hs_active_next = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
    vs_active_next = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    blank_next     = (h_next >= H_VIS_END) || (v_next >= V_VIS_END);
  end

  // Raster counters and aligned timing outputs; async reset restarts at (0,0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= 12'd0;
      vcount      <= 11'd0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= hs_active_next ? HS_POL : ~HS_POL;
      vsync       <= vs_active_next ? VS_POL : ~VS_POL;
      blank       <= blank_next;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: three instances (small mode at CLK_DIV=1,
// small mode at CLK_DIV=3 with negative syncs, default 800x600 mode).

module tb_vga_sync_gen;

  logic clk;
  logic rst;

  logic [11:0] a_hcount, b_hcount, d_hcount;
  logic [10:0] a_vcount, b_vcount, d_vcount;
  logic a_hsync, a_vsync, a_blank, a_pix_en, a_line_start, a_frame_start;
  logic b_hsync, b_vsync, b_blank, b_pix_en, b_line_start, b_frame_start;
  logic d_hsync, d_vsync, d_blank, d_pix_en, d_line_start, d_frame_start;

  int vec_count;
  int miss_count;

  // Small mode: H 16/4/6/4 (total 30, sync 20..25), V 10/2/3/2 (total 17, sync 12..14)
  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
  ) dut_a (
    .clk(clk), .rst(rst), .hcount(a_hcount), .vcount(a_vcount),
    .hsync(a_hsync), .vsync(a_vsync), .blank(a_blank), .pix_en(a_pix_en),
    .line_start(a_line_start), .frame_start(a_frame_start)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3)
  ) dut_b (
    .clk(clk), .rst(rst), .hcount(b_hcount), .vcount(b_vcount),
    .hsync(b_hsync), .vsync(b_vsync), .blank(b_blank), .pix_en(b_pix_en),
    .line_start(b_line_start), .frame_start(b_frame_start)
  );

  vga_sync_gen dut_d (
    .clk(clk), .rst(rst), .hcount(d_hcount), .vcount(d_vcount),
    .hsync(d_hsync), .vsync(d_vsync), .blank(d_blank), .pix_en(d_pix_en),
    .line_start(d_line_start), .frame_start(d_frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [11:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        ls;
    logic        fs;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [28:0] snap_a();
    return {a_hcount, a_vcount, a_hsync, a_vsync, a_blank, a_pix_en, a_line_start, a_frame_start};
  endfunction

  function automatic logic [28:0] snap_b();
    return {b_hcount, b_vcount, b_hsync, b_vsync, b_blank, b_pix_en, b_line_start, b_frame_start};
  endfunction

  function automatic logic [28:0] snap_d();
    return {d_hcount, d_vcount, d_hsync, d_vsync, d_blank, d_pix_en, d_line_start, d_frame_start};
  endfunction

  // Expected outputs k clk edges after reset release, from raster arithmetic
  function automatic logic [28:0] model(input int k, input int div, input int ht, input int vt,
                                        input int hact, input int hs0, input int hs1,
                                        input int vact, input int vs0, input int vs1,
                                        input logic hpol, input logic vpol);
    int p, h, v;
    logic hs, vs, bl, pe, ls, fs;
    p  = k / div;
    h  = p % ht;
    v  = (p / ht) % vt;
    pe = ((k % div) == div - 1);
    ls = (k > 0) && ((k % (div * ht)) == 0);
    fs = (k > 0) && ((k % (div * ht * vt)) == 0);
    hs = (h >= hs0 && h <= hs1) ? hpol : ~hpol;
    vs = (v >= vs0 && v <= vs1) ? vpol : ~vpol;
    bl = (h >= hact) || (v >= vact);
    return {12'(h), 11'(v), hs, vs, bl, pe, ls, fs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_val, input int cycles);
    rst = rst_val;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic checkOutput(input string name, input logic [28:0] act, input logic [28:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got h=%0d v=%0d hs=%b vs=%b bl=%b pe=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b bl=%b pe=%b ls=%b fs=%b",
               name, act[28:17], act[16:6], act[5], act[4], act[3], act[2], act[1], act[0],
               exp[28:17], exp[16:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    vec_count++;
    if (act != exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reset values of each instance
  localparam logic [28:0] RST_A = {12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [28:0] RST_B = {12'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [28:0] RST_D = {12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int k_now;
    int n;
    int lines;
    bit found;

    vec_count  = 0;
    miss_count = 0;

    //          k    h       v      hs    vs    bl    ls    fs
    vecs[0]  = '{1,   12'd1,  11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{15,  12'd15, 11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16,  12'd16, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{19,  12'd19, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{20,  12'd20, 11'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{25,  12'd25, 11'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{26,  12'd26, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{29,  12'd29, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{30,  12'd0,  11'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{31,  12'd1,  11'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{300, 12'd0,  11'd10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{359, 12'd29, 11'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{360, 12'd0,  11'd12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{449, 12'd29, 11'd14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{450, 12'd0,  11'd15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{509, 12'd29, 11'd16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{510, 12'd0,  11'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{511, 12'd1,  11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Power-on reset
    rst = 1'b1;
    applyStimulus(1'b1, 5);
    checkOutput("reset_a", snap_a(), RST_A);
    checkOutput("reset_b", snap_b(), RST_B);
    checkOutput("reset_d", snap_d(), RST_D);

    // Run briefly, then assert reset between clock edges
    applyStimulus(1'b0, 7);
    checkOutput("run7_a", snap_a(),
                model(7, 1, 30, 17, 16, 20, 25, 10, 12, 14, 1'b1, 1'b1));
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_a", snap_a(), RST_A);
    checkOutput("async_reset_b", snap_b(), RST_B);
    applyStimulus(1'b1, 5);
    checkOutput("held_reset_a", snap_a(), RST_A);

    // Table-driven walk through one full frame of the small mode
    k_now = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, vecs[i].k - k_now);
      k_now = vecs[i].k;
      checkOutput($sformatf("vec%0d_k%0d", i, vecs[i].k), snap_a(),
                  {vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].bl, 1'b1,
                   vecs[i].ls, vecs[i].fs});
    end

    // Cycle-by-cycle sweep over all three instances from a fresh reset
    applyStimulus(1'b1, 2);
    rst = 1'b0;
    for (int k = 1; k <= 1540; k++) begin
      tick();
      checkOutput($sformatf("sweep_a_k%0d", k), snap_a(),
                  model(k, 1, 30, 17, 16, 20, 25, 10, 12, 14, 1'b1, 1'b1));
      checkOutput($sformatf("sweep_b_k%0d", k), snap_b(),
                  model(k, 3, 30, 17, 16, 20, 25, 10, 12, 14, 1'b0, 1'b0));
      checkOutput($sformatf("sweep_d_k%0d", k), snap_d(),
                  model(k, 1, 1040, 666, 800, 856, 975, 600, 637, 642, 1'b1, 1'b1));
    end

    // Mid-frame reset while both syncs are active
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 412);
    checkOutput("midframe_pos_a", snap_a(),
                {12'd22, 11'd13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    #2 rst = 1'b1;
    #1;
    checkOutput("midframe_reset_a", snap_a(), RST_A);
    tick();
    applyStimulus(1'b1, 2);

    // Next frame_start after release must come a full frame later
    rst = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 600) begin
      tick();
      n++;
      if (a_frame_start) found = 1'b1;
    end
    checkValue("first_frame_start_delay", n, 510);

    // One frame period, counting line_start pulses up to and including the next frame_start
    n = 0;
    lines = 0;
    found = 1'b0;
    while (!found && n < 600) begin
      tick();
      n++;
      if (a_line_start) lines++;
      if (a_frame_start) found = 1'b1;
    end
    checkValue("frame_period", n, 510);
    checkValue("lines_per_frame", lines, 17);
    checkValue("line_start_with_frame_start", int'(a_line_start), 1);
    tick();
    checkValue("frame_start_one_cycle", int'(a_frame_start), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
